// File: rtl/updn_modcount.sv
// updn_modcount: up/down counter with a programmable modulus (last = M-1),
// parallel load, wrap or saturate at the boundary, a registered boundary
// pulse and a sticky error flag.
module updn_modcount #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned LAST_DEFAULT = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             updn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_last,
    input  logic             err_clr,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] last,
    output logic             tc,
    output logic             err,
    output logic             at_zero,
    output logic             at_last
);

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] LAST_INIT = WIDTH'(LAST_DEFAULT);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] last_q,  last_d;
    logic             tc_q,    tc_d;
    logic             err_q,   err_d;
    logic             err_set;

    // Next-state selection: mod_wr > load > en > hold. Count never exceeds
    // last (mod_wr zeroes it, load rejects values above last), so the
    // boundary test only needs equality.
    always_comb begin
        count_d = count_q;
        last_d  = last_q;
        tc_d    = 1'b0;
        err_set = 1'b0;
        if (mod_wr) begin
            last_d  = mod_last;
            count_d = '0;
        end else if (load) begin
            if (load_val <= last_q) begin
                count_d = load_val;
            end else begin
                err_set = 1'b1;
            end
        end else if (en) begin
            if (updn) begin
                if (count_q == last_q) begin
                    tc_d = 1'b1;
                    if (sat_mode) begin
                        err_set = 1'b1;
                    end else begin
                        count_d = '0;
                    end
                end else begin
                    count_d = count_q + ONE;
                end
            end else begin
                if (count_q == '0) begin
                    tc_d = 1'b1;
                    if (sat_mode) begin
                        err_set = 1'b1;
                    end else begin
                        count_d = last_q;
                    end
                end else begin
                    count_d = count_q - ONE;
                end
            end
        end
        // Setting the flag takes precedence over a coincident clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            last_q  <= LAST_INIT;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            last_q  <= last_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
        end
    end

    assign count   = count_q;
    assign last    = last_q;
    assign tc      = tc_q;
    assign err     = err_q;
    assign at_zero = (count_q == '0);
    assign at_last = (count_q == last_q);

endmodule

// File: tb/tb_updn_modcount.sv
// Directed self-checking bench for updn_modcount (WIDTH=8, LAST_DEFAULT=7).
module tb_updn_modcount;

    logic       clk = 1'b0;
    logic       rst, en, updn, sat_mode, load, mod_wr, err_clr;
    logic [7:0] load_val, mod_last;
    logic [7:0] count, last;
    logic       tc, err, at_zero, at_last;

    int n_pass  = 0;
    int n_total = 0;

    updn_modcount #(.WIDTH(8), .LAST_DEFAULT(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .updn     (updn),
        .sat_mode (sat_mode),
        .load     (load),
        .load_val (load_val),
        .mod_wr   (mod_wr),
        .mod_last (mod_last),
        .err_clr  (err_clr),
        .count    (count),
        .last     (last),
        .tc       (tc),
        .err      (err),
        .at_zero  (at_zero),
        .at_last  (at_last)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int c, input int l,
                             input int t, input int e);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".last"},  int'(last),  l);
        chk({tag, ".tc"},    int'(tc),    t);
        chk({tag, ".err"},   int'(err),   e);
    endtask

    task automatic idle();
        en = 0; load = 0; mod_wr = 0; err_clr = 0;
    endtask

    initial begin
        // Reset overrides concurrent en and mod_wr.
        rst = 0; en = 1; updn = 1; sat_mode = 0; load = 1; load_val = 8'd3;
        mod_wr = 1; mod_last = 8'd3; err_clr = 0;
        step();
        chk_state("reset", 0, 7, 0, 0);
        chk("reset.at_zero", int'(at_zero), 1);
        chk("reset.at_last", int'(at_last), 0);

        // Wrap-up: 1..7, 0, 1 with tc only when count shows 0.
        rst = 1; idle(); en = 1; updn = 1; sat_mode = 0;
        for (int i = 1; i <= 9; i++) begin
            step();
            chk($sformatf("wrapup%0d.count", i), int'(count), i % 8);
            chk($sformatf("wrapup%0d.tc", i), int'(tc), (i % 8 == 0) ? 1 : 0);
        end
        // Hold with don't-care direction/mode inputs.
        idle(); updn = 0; sat_mode = 1; load_val = 8'hFF; mod_last = 8'h00;
        step();
        chk_state("hold", 1, 7, 0, 0);

        // Wrap-down after reset.
        rst = 0; step(); rst = 1;
        en = 1; updn = 0; sat_mode = 0;
        step();
        chk_state("wrapdn0", 7, 7, 1, 0);
        chk("wrapdn0.at_last", int'(at_last), 1);
        step();
        chk_state("wrapdn1", 6, 7, 0, 0);
        step();
        chk_state("wrapdn2", 5, 7, 0, 0);

        // Saturate up at last.
        idle(); load = 1; load_val = 8'd7;
        step();
        chk_state("ld7", 7, 7, 0, 0);
        idle(); en = 1; updn = 1; sat_mode = 1;
        step();
        chk_state("satup", 7, 7, 1, 1);
        idle();
        step();
        chk_state("satup_hold", 7, 7, 0, 1);
        err_clr = 1;
        step();
        chk_state("errclr", 7, 7, 0, 0);

        // Set wins over coincident clear.
        en = 1; updn = 1; sat_mode = 1; err_clr = 1;
        step();
        chk_state("setwins", 7, 7, 1, 1);
        en = 0;
        step();
        chk_state("clr2", 7, 7, 0, 0);

        // Saturate down at zero.
        idle(); load = 1; load_val = 8'd0;
        step();
        idle(); en = 1; updn = 0; sat_mode = 1;
        step();
        chk_state("satdn", 0, 7, 1, 1);
        idle(); err_clr = 1;
        step();
        chk("satdn_clr.err", int'(err), 0);

        // Modulus write beats load and en in the same cycle.
        idle(); mod_wr = 1; mod_last = 8'd4; load = 1; load_val = 8'd2; en = 1; updn = 1; sat_mode = 0;
        step();
        chk_state("modwr", 0, 4, 0, 0);
        idle(); load = 1; load_val = 8'd6;
        step();
        chk_state("ld_bad", 0, 4, 0, 1);
        load_val = 8'd3;
        step();
        chk_state("ld3", 3, 4, 0, 1);
        load_val = 8'd4;
        step();
        chk("ld4.count", int'(count), 4);
        chk("ld4.at_last", int'(at_last), 1);
        idle(); en = 1; updn = 1; sat_mode = 0;
        step();
        chk_state("wrap_m5", 0, 4, 1, 1);
        updn = 0;
        step();
        chk_state("wrapdn_m5", 4, 4, 1, 1);
        idle(); err_clr = 1;
        step();
        chk_state("clr3", 4, 4, 0, 0);

        // M = 1: every enabled step is a boundary.
        idle(); mod_wr = 1; mod_last = 8'd0;
        step();
        idle(); en = 1; updn = 1; sat_mode = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_state($sformatf("m1_%0d", i), 0, 0, 1, 0);
        end
        chk("m1.at_zero", int'(at_zero), 1);
        chk("m1.at_last", int'(at_last), 1);
        updn = 0;
        step();
        chk_state("m1_dn", 0, 0, 1, 0);
        sat_mode = 1;
        step();
        chk_state("m1_sat", 0, 0, 1, 1);
        idle(); err_clr = 1;
        step();
        chk_state("m1_idle", 0, 0, 0, 0);

        // Full-range modulus wraps at 2^WIDTH.
        idle(); mod_wr = 1; mod_last = 8'd255;
        step();
        idle(); load = 1; load_val = 8'd255;
        step();
        chk_state("full_ld", 255, 255, 0, 0);
        idle(); en = 1; updn = 1; sat_mode = 0;
        step();
        chk_state("full_wrap", 0, 255, 1, 0);
        updn = 0;
        step();
        chk_state("full_wrapdn", 255, 255, 1, 0);

        // Reset discards a written modulus.
        idle(); mod_wr = 1; mod_last = 8'd2;
        step();
        chk("mod2.last", int'(last), 2);
        idle(); rst = 0;
        step();
        chk_state("rst_mod", 0, 7, 0, 0);
        rst = 1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
